// File: rtl/bsrch_sqrt_arbiter_if.sv
// Requester-side and engine-side signals of the shared sqrt arbiter.
// The arbiter uses "master"; the environment (clients plus engine) uses "slave".
interface bsrch_sqrt_arbiter_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = 8,
   parameter int unsigned RW   = 4
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_n;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    rsp_valid;
   logic [RW-1:0]      rsp_root;
   logic               rsp_timeout;
   logic               eng_start;
   logic [DW-1:0]      eng_n;
   logic               eng_done;
   logic [RW-1:0]      eng_root;
   logic               busy;

   modport master (
      input  req_valid, req_n, eng_done, eng_root,
      output req_ready, rsp_valid, rsp_root, rsp_timeout, eng_start, eng_n, busy
   );

   modport slave (
      output req_valid, req_n, eng_done, eng_root,
      input  req_ready, rsp_valid, rsp_root, rsp_timeout, eng_start, eng_n, busy
   );
endinterface

// File: rtl/bsrch_sqrt_arbiter.sv
// Round-robin scheduler sharing one integer square-root engine between NREQ requesters.
// It accepts one job at a time, launches the engine, and returns the root (or a timeout) to the requester.
module bsrch_sqrt_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned DW      = 8,
   parameter int unsigned RW      = 4,
   parameter int unsigned TIMEOUT = 31
) (
   input logic                  clk,
   input logic                  rst,
   bsrch_sqrt_arbiter_if.master bus
);
   localparam int unsigned PW = $clog2(NREQ);
   localparam int unsigned CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_RESP
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   id_q, id_d;
   logic [DW-1:0]   opnd_q, opnd_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]   root_q, root_d;
   logic            tmo_q, tmo_d;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;

   logic            found;
   logic [PW-1:0]   winner;
   int unsigned     idx;
   logic [NREQ-1:0] ready_c;
   logic            start_c;

   // First valid requester at or after ptr, wrapping around.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = (32'(ptr_q) + k) % NREQ;
         if (!found && bus.req_valid[idx[PW-1:0]]) begin
            found  = 1'b1;
            winner = idx[PW-1:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      opnd_d      = opnd_q;
      cnt_d       = cnt_q;
      root_d      = root_q;
      tmo_d       = tmo_q;
      rsp_valid_d = '0;
      ready_c     = '0;
      start_c     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               ready_c[winner] = 1'b1;
               id_d            = winner;
               opnd_d          = bus.req_n[32'(winner)*DW +: DW];
               ptr_d           = (winner == PW'(NREQ-1)) ? '0 : winner + 1'b1;
               state_d         = S_START;
            end
         end
         S_START: begin
            start_c = 1'b1;
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A done arriving in the expiry cycle takes precedence over the timeout.
            if (bus.eng_done) begin
               root_d              = bus.eng_root;
               tmo_d               = 1'b0;
               rsp_valid_d[id_q]   = 1'b1;
               state_d             = S_RESP;
            end else if (cnt_q == CW'(TIMEOUT-1)) begin
               root_d              = '0;
               tmo_d               = 1'b1;
               rsp_valid_d[id_q]   = 1'b1;
               state_d             = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         opnd_q      <= '0;
         cnt_q       <= '0;
         root_q      <= '0;
         tmo_q       <= 1'b0;
         rsp_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         opnd_q      <= opnd_d;
         cnt_q       <= cnt_d;
         root_q      <= root_d;
         tmo_q       <= tmo_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign bus.req_ready   = ready_c;
   assign bus.eng_start   = start_c;
   assign bus.eng_n       = opnd_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_root    = root_q;
   assign bus.rsp_timeout = tmo_q;
   assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_bsrch_sqrt_arbiter.sv
// Bench for bsrch_sqrt_arbiter: engine model driven from the tasks, expectations from
// a round-robin model (pointer + modulo search) and an arithmetic floor-sqrt.
module tb_bsrch_sqrt_arbiter;
   localparam int NREQ    = 4;
   localparam int DW      = 8;
   localparam int RW      = 4;
   localparam int TIMEOUT = 31;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests_run = 0;
   int   fails     = 0;
   int   mdl_ptr   = 0;

   always #5 clk = ~clk;

   bsrch_sqrt_arbiter_if #(.NREQ(NREQ), .DW(DW), .RW(RW)) bus ();

   bsrch_sqrt_arbiter #(
      .NREQ(NREQ), .DW(DW), .RW(RW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   function automatic int isqrt(input int n);
      int r = 0;
      while ((r + 1) * (r + 1) <= n) r++;
      return r;
   endfunction

   // Round-robin reference: first valid index searching upward from the pointer.
   function automatic int mdl_winner(input logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++)
         if (v[(mdl_ptr + k) % NREQ]) return (mdl_ptr + k) % NREQ;
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_n(input int i, input int n);
      bus.req_n[i*DW +: DW] = DW'(n);
   endtask

   task automatic apply_reset();
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_n     = '0;
      bus.eng_done  = 1'b0;
      bus.eng_root  = '0;
      step();
      step();
      rst     = 1'b0;
      mdl_ptr = 0;
   endtask

   // Runs one job from an IDLE cycle whose requests were just driven. delay = WAIT cycle index
   // at which the engine model raises done (-1: never); root_force < 0 returns floor(sqrt(eng_n)).
   task automatic run_job(input int delay, input int root_force,
                          output logic [NREQ-1:0] ready, output logic start_ok,
                          output logic start_after, output logic busy_wait,
                          output logic [DW-1:0] nseen, output int rsp_at,
                          output logic [NREQ-1:0] rsp_v, output logic [RW-1:0] rsp_r,
                          output logic rsp_t);
      #1;
      ready = bus.req_ready;
      step();
      start_ok    = bus.eng_start;
      nseen       = bus.eng_n;
      start_after = 1'b1;
      busy_wait   = 1'b0;
      rsp_at      = -1;
      rsp_v       = '0;
      rsp_r       = '0;
      rsp_t       = 1'b0;
      for (int w = 0; w <= TIMEOUT + 3; w++) begin
         step();
         bus.eng_done = 1'b0;
         if (w == 0) begin
            start_after = bus.eng_start;
            busy_wait   = bus.busy;
         end
         if (bus.rsp_valid != '0) begin
            rsp_at = w;
            rsp_v  = bus.rsp_valid;
            rsp_r  = bus.rsp_root;
            rsp_t  = bus.rsp_timeout;
            break;
         end
         if (w == delay) begin
            bus.eng_done = 1'b1;
            bus.eng_root = (root_force >= 0) ? RW'(root_force) : RW'(isqrt(int'(bus.eng_n)));
         end
      end
      bus.eng_done = 1'b0;
      step();
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      tests_run++;
      if ({bus.busy, bus.rsp_valid, bus.rsp_root, bus.rsp_timeout, bus.eng_start, bus.eng_n, bus.req_ready} !== '0) begin
         fails++;
         $display("FAIL reset_state: busy=%b rsp_v=%b root=%0d tmo=%b start=%b n=%0d ready=%b, want all zero",
                  bus.busy, bus.rsp_valid, bus.rsp_root, bus.rsp_timeout, bus.eng_start, bus.eng_n, bus.req_ready);
      end
   endtask

   task automatic test_single();
      logic [NREQ-1:0] ready, rv;
      logic st, sa, bw, rt;
      logic [DW-1:0] ns;
      logic [RW-1:0] rr;
      int at;
      apply_reset();
      bus.req_valid = 4'b0100;
      set_n(2, 101);
      run_job(2, -1, ready, st, sa, bw, ns, at, rv, rr, rt);
      bus.req_valid = '0;
      mdl_ptr = 3;
      tests_run++;
      if (ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b want 0100", ready); end
      tests_run++;
      if ({st, sa, bw} !== 3'b101) begin fails++; $display("FAIL single_start_pulse: start,next,busy=%b%b%b want 101", st, sa, bw); end
      tests_run++;
      if (ns !== 8'd101) begin fails++; $display("FAIL single_eng_n: got %0d want 101", ns); end
      tests_run++;
      if (at !== 3) begin fails++; $display("FAIL single_latency: rsp at WAIT+%0d want WAIT+3", at); end
      tests_run++;
      if ({rv, rr, rt} !== {4'b0100, 4'd10, 1'b0}) begin
         fails++; $display("FAIL single_rsp: v=%b root=%0d tmo=%b want 0100/10/0", rv, rr, rt);
      end
   endtask

   task automatic test_fairness();
      logic [NREQ-1:0] ready, rv;
      logic st, sa, bw, rt;
      logic [DW-1:0] ns;
      logic [RW-1:0] rr;
      int at, w, d;
      int nv[NREQ] = '{0, 16, 200, 255};
      int order[5] = '{0, 1, 2, 3, 0};
      apply_reset();
      for (int i = 0; i < NREQ; i++) set_n(i, nv[i]);
      bus.req_valid = '1;
      for (int j = 0; j < 5; j++) begin
         w = mdl_winner(bus.req_valid);
         d = int'($urandom_range(0, 4));
         run_job(d, -1, ready, st, sa, bw, ns, at, rv, rr, rt);
         mdl_ptr = (w + 1) % NREQ;
         tests_run++;
         if (ready !== NREQ'(1 << order[j]) || w != order[j]) begin
            fails++; $display("FAIL fair_grant[%0d]: ready=%b want onehot %0d", j, ready, order[j]);
         end
         tests_run++;
         if ({rv, rr, rt} !== {NREQ'(1 << w), RW'(isqrt(nv[w])), 1'b0} || at != d + 1) begin
            fails++; $display("FAIL fair_rsp[%0d]: v=%b root=%0d tmo=%b at=%0d want %b/%0d/0 at %0d",
                              j, rv, rr, rt, at, NREQ'(1 << w), isqrt(nv[w]), d + 1);
         end
      end
      bus.req_valid = '0;
   endtask

   task automatic test_rotation();
      logic [NREQ-1:0] ready, rv;
      logic st, sa, bw, rt;
      logic [DW-1:0] ns;
      logic [RW-1:0] rr;
      int at;
      int order[4] = '{0, 3, 0, 3};
      apply_reset();
      set_n(0, 9);
      set_n(3, 144);
      bus.req_valid = 4'b1001;
      for (int j = 0; j < 4; j++) begin
         run_job(0, -1, ready, st, sa, bw, ns, at, rv, rr, rt);
         tests_run++;
         if (ready !== NREQ'(1 << order[j]) || rv !== NREQ'(1 << order[j])) begin
            fails++; $display("FAIL rot_grant[%0d]: ready=%b rsp=%b want onehot %0d", j, ready, rv, order[j]);
         end
      end
      bus.req_valid = '0;
   endtask

   task automatic test_timeout();
      logic [NREQ-1:0] ready, rv;
      logic st, sa, bw, rt;
      logic [DW-1:0] ns;
      logic [RW-1:0] rr;
      int at;
      apply_reset();
      set_n(1, 77);
      bus.req_valid = 4'b0010;
      run_job(-1, -1, ready, st, sa, bw, ns, at, rv, rr, rt);
      tests_run++;
      if (at !== TIMEOUT || {rv, rr, rt} !== {4'b0010, 4'd0, 1'b1}) begin
         fails++; $display("FAIL timeout_rsp: at=%0d v=%b root=%0d tmo=%b want at=%0d 0010/0/1", at, rv, rr, rt, TIMEOUT);
      end
      tests_run++;
      if (bus.busy !== 1'b0) begin fails++; $display("FAIL timeout_idle: busy=%b want 0", bus.busy); end
      run_job(1, -1, ready, st, sa, bw, ns, at, rv, rr, rt);
      tests_run++;
      if (at !== 2 || {rv, rr, rt} !== {4'b0010, 4'd8, 1'b0}) begin
         fails++; $display("FAIL timeout_next: at=%0d v=%b root=%0d tmo=%b want at=2 0010/8/0", at, rv, rr, rt);
      end
      bus.req_valid = '0;
   endtask

   task automatic test_expiry_done();
      logic [NREQ-1:0] ready, rv;
      logic st, sa, bw, rt;
      logic [DW-1:0] ns;
      logic [RW-1:0] rr;
      int at;
      apply_reset();
      set_n(3, 50);
      bus.req_valid = 4'b1000;
      run_job(TIMEOUT - 1, 9, ready, st, sa, bw, ns, at, rv, rr, rt);
      bus.req_valid = '0;
      tests_run++;
      if (at !== TIMEOUT || {rv, rr, rt} !== {4'b1000, 4'd9, 1'b0}) begin
         fails++; $display("FAIL expiry_done: at=%0d v=%b root=%0d tmo=%b want at=%0d 1000/9/0", at, rv, rr, rt, TIMEOUT);
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [NREQ-1:0] ready, rv, seen;
      logic st, sa, bw, rt, bsy;
      logic [DW-1:0] ns;
      logic [RW-1:0] rr;
      int at;
      apply_reset();
      for (int i = 0; i < NREQ; i++) set_n(i, 30 + i);
      bus.req_valid = 4'b0001;
      run_job(0, -1, ready, st, sa, bw, ns, at, rv, rr, rt);
      bus.req_valid = 4'b0110;
      step();
      bus.req_valid = '0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.eng_done = 1'b1;
      bus.eng_root = 4'd7;
      seen = '0;
      bsy  = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         seen = seen | bus.rsp_valid;
         bsy  = bsy | bus.busy;
         step();
         bus.eng_done = 1'b0;
      end
      tests_run++;
      if (seen !== '0 || bsy !== 1'b0) begin
         fails++; $display("FAIL rstwait_quiet: rsp seen=%b busy=%b want 0000/0", seen, bsy);
      end
      mdl_ptr = 0;
      bus.req_valid = '1;
      run_job(0, -1, ready, st, sa, bw, ns, at, rv, rr, rt);
      bus.req_valid = '0;
      tests_run++;
      if (ready !== 4'b0001 || rv !== 4'b0001) begin
         fails++; $display("FAIL rstwait_ptr: ready=%b rsp=%b want 0001", ready, rv);
      end
   endtask

   task automatic test_random();
      logic [NREQ-1:0] ready, rv, mask;
      logic st, sa, bw, rt;
      logic [DW-1:0] ns;
      logic [RW-1:0] rr;
      int at, w, d, sel, exp_at, exp_root;
      int nv[NREQ];
      apply_reset();
      for (int j = 0; j < 16; j++) begin
         mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++) begin
            nv[i] = int'($urandom_range(0, 255));
            set_n(i, nv[i]);
         end
         sel = int'($urandom_range(0, 9));
         d   = (sel == 0) ? -1 : (sel == 1) ? TIMEOUT - 1 : int'($urandom_range(0, 6));
         exp_at   = (d < 0) ? TIMEOUT : d + 1;
         w        = mdl_winner(mask);
         exp_root = (d < 0) ? 0 : isqrt(nv[w]);
         bus.req_valid = mask;
         run_job(d, -1, ready, st, sa, bw, ns, at, rv, rr, rt);
         bus.req_valid = '0;
         mdl_ptr = (w + 1) % NREQ;
         tests_run++;
         if (ready !== NREQ'(1 << w) || ns !== DW'(nv[w]) || st !== 1'b1) begin
            fails++; $display("FAIL rand_grant[%0d]: mask=%b ready=%b n=%0d start=%b want onehot %0d n=%0d",
                              j, mask, ready, ns, st, w, nv[w]);
         end
         tests_run++;
         if (at !== exp_at || {rv, rr, rt} !== {NREQ'(1 << w), RW'(exp_root), d < 0}) begin
            fails++; $display("FAIL rand_rsp[%0d]: at=%0d v=%b root=%0d tmo=%b want at=%0d %b/%0d/%b",
                              j, at, rv, rr, rt, exp_at, NREQ'(1 << w), exp_root, d < 0);
         end
      end
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_n     = '0;
      bus.eng_done  = 1'b0;
      bus.eng_root  = '0;
      test_reset();
      test_single();
      test_fairness();
      test_rotation();
      test_timeout();
      test_expiry_done();
      test_reset_mid_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
